// File: rtl/dbg_cmd_decoder.sv
// dbg_cmd_decoder: assembles UART bytes into little-endian 32-bit words and decodes
// debugger commands driving CPU reset/clock and the instruction-memory write port.
`default_nettype none

module dbg_cmd_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 104160,
  parameter int unsigned IMEM_AW        = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               cpu_reset,
  output logic               cpu_clk,
  output logic               imem_prog,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               word_valid,
  output logic [31:0]        word,
  output logic               timeout
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [31:0] CMD_RST1 = 32'h3154_5352;
  localparam logic [31:0] CMD_RST0 = 32'h3054_5352;
  localparam logic [31:0] CMD_IMEN = 32'h6E45_4D49;
  localparam logic [31:0] CMD_CCLK = 32'h6B6C_6363;
  localparam logic [31:0] CMD_ZERO = 32'h3030_3030;

  localparam logic [1:0] P_ADDR  = 2'd0;
  localparam logic [1:0] P_DATA  = 2'd1;
  localparam logic [1:0] P_READY = 2'd2;

  logic [31:0]        word_q, word_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic               word_valid_q, word_valid_d;
  logic               timeout_q, timeout_d;
  logic               cpu_reset_q, cpu_reset_d;
  logic               cpu_clk_q, cpu_clk_d;
  logic               imem_prog_q, imem_prog_d;
  logic               imem_we_q, imem_we_d;
  logic [IMEM_AW-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]        imem_wdata_q, imem_wdata_d;
  logic [1:0]         pstate_q, pstate_d;

  // Byte assembly and inter-byte timeout; a byte arriving on the expiry cycle wins.
  always_comb begin
    word_d       = word_q;
    byte_cnt_d   = byte_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    word_valid_d = 1'b0;
    timeout_d    = 1'b0;
    if (rx_valid) begin
      word_d       = {rx_data, word_q[31:8]};
      byte_cnt_d   = byte_cnt_q + 2'd1;
      word_valid_d = (byte_cnt_q == 2'd3);
      idle_cnt_d   = '0;
    end else if (byte_cnt_q != 2'd0) begin
      if (idle_cnt_q == IDLE_LAST) begin
        byte_cnt_d = 2'd0;
        idle_cnt_d = '0;
        timeout_d  = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt_q + CNT_W'(1);
      end
    end else begin
      idle_cnt_d = '0;
    end
  end

  always_comb begin
    cpu_reset_d  = cpu_reset_q;
    cpu_clk_d    = cpu_clk_q;
    imem_prog_d  = imem_prog_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    pstate_d     = pstate_q;
    if (word_valid_q) begin
      case (word_q)
        CMD_RST1: cpu_reset_d = 1'b1;
        CMD_RST0: cpu_reset_d = 1'b0;
        CMD_IMEN: begin
          imem_prog_d = ~imem_prog_q;
          pstate_d    = P_ADDR;
          if (!imem_prog_q) cpu_clk_d = 1'b0;
        end
        CMD_CCLK: begin
          if (!imem_prog_q) begin
            cpu_clk_d = 1'b1;
          end else if (pstate_q == P_READY) begin
            imem_we_d = 1'b1;
            pstate_d  = P_ADDR;
          end
        end
        CMD_ZERO: begin
          if (!imem_prog_q) cpu_clk_d = 1'b0;
        end
        default: begin
          if (imem_prog_q) begin
            if (pstate_q == P_DATA) begin
              imem_wdata_d = word_q;
              pstate_d     = P_READY;
            end else begin
              imem_addr_d = word_q[IMEM_AW-1:0];
              pstate_d    = P_DATA;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q       <= '0;
      byte_cnt_q   <= 2'd0;
      idle_cnt_q   <= '0;
      word_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      cpu_reset_q  <= 1'b1;
      cpu_clk_q    <= 1'b0;
      imem_prog_q  <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      pstate_q     <= P_ADDR;
    end else begin
      word_q       <= word_d;
      byte_cnt_q   <= byte_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      word_valid_q <= word_valid_d;
      timeout_q    <= timeout_d;
      cpu_reset_q  <= cpu_reset_d;
      cpu_clk_q    <= cpu_clk_d;
      imem_prog_q  <= imem_prog_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      pstate_q     <= pstate_d;
    end
  end

  assign cpu_reset  = cpu_reset_q;
  assign cpu_clk    = cpu_clk_q;
  assign imem_prog  = imem_prog_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign word_valid = word_valid_q;
  assign word       = word_q;
  assign timeout    = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_dbg_cmd_decoder.sv
// tb_dbg_cmd_decoder: directed-vector bench for the debugger command decoder.
`default_nettype none

module tb_dbg_cmd_decoder;

  localparam int TC = 20;
  localparam int AW = 8;

  localparam logic [31:0] RST1 = 32'h3154_5352;
  localparam logic [31:0] RST0 = 32'h3054_5352;
  localparam logic [31:0] IMEN = 32'h6E45_4D49;
  localparam logic [31:0] CCLK = 32'h6B6C_6363;
  localparam logic [31:0] ZERO = 32'h3030_3030;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          cpu_reset, cpu_clk, imem_prog, imem_we, word_valid, timeout;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata, word;

  int n_tests = 0;
  int n_fail  = 0;
  int we_cnt  = 0;
  int to_cnt  = 0;
  int clk_viol = 0;
  logic [AW-1:0] last_addr = '0;
  logic [31:0]   last_wdata = '0;

  dbg_cmd_decoder #(.TIMEOUT_CYCLES(TC), .IMEM_AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .cpu_reset  (cpu_reset),
    .cpu_clk    (cpu_clk),
    .imem_prog  (imem_prog),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .word_valid (word_valid),
    .word       (word),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_we) begin
      we_cnt++;
      last_addr  = imem_addr;
      last_wdata = imem_wdata;
    end
    if (timeout) to_cnt++;
  end

  always @(negedge clk) if (imem_prog && cpu_clk) clk_viol++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Four back-to-back bytes; returns one cycle after the last byte is taken.
  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rx_data  = w[8*i +: 8];
      rx_valid = 1'b1;
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Sends a word and steps to the cycle where its command effects are visible.
  task automatic send_cmd(input logic [31:0] w);
    send_word(w);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    check_eq({tag, "_cpu_clk"},   32'(cpu_clk),   32'd0);
    check_eq({tag, "_imem_prog"}, 32'(imem_prog), 32'd0);
    check_eq({tag, "_imem_we"},   32'(imem_we),   32'd0);
    check_eq({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
    check_eq({tag, "_imem_wdata"}, imem_wdata,    32'd0);
    check_eq({tag, "_word"},       word,          32'd0);
    check_eq({tag, "_word_valid"}, 32'(word_valid), 32'd0);
    check_eq({tag, "_timeout"},    32'(timeout),    32'd0);
  endtask

  initial begin
    int first_to;
    int base_we;
    int base_to;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_state("rst");

    // RST0 then RST1 with exact latency
    send_word(RST0);
    check_eq("rst0_word", word, 32'h3054_5352);
    check_eq("rst0_wvalid", 32'(word_valid), 32'd1);
    check_eq("rst0_cpurst_t1", 32'(cpu_reset), 32'd1);
    @(negedge clk);
    check_eq("rst0_cpurst_t2", 32'(cpu_reset), 32'd0);
    check_eq("rst0_wvalid_t2", 32'(word_valid), 32'd0);
    send_cmd(RST1);
    check_eq("rst1_cpurst", 32'(cpu_reset), 32'd1);

    // Manual clock outside programming mode
    send_word(CCLK);
    check_eq("cclk_t1", 32'(cpu_clk), 32'd0);
    @(negedge clk);
    check_eq("cclk_t2", 32'(cpu_clk), 32'd1);
    send_word(ZERO);
    check_eq("zero_t1", 32'(cpu_clk), 32'd1);
    @(negedge clk);
    check_eq("zero_t2", 32'(cpu_clk), 32'd0);
    check_eq("noprog_we_cnt", 32'(we_cnt), 32'd0);

    // Programming sequence with one write
    send_cmd(IMEN);
    check_eq("imen_prog", 32'(imem_prog), 32'd1);
    send_cmd(32'h0000_0002);
    check_eq("prog_addr", 32'(imem_addr), 32'd2);
    send_cmd(32'h0043_2806);
    check_eq("prog_wdata", imem_wdata, 32'h0043_2806);
    send_word(CCLK);
    check_eq("prog_we_t1", 32'(imem_we), 32'd0);
    @(negedge clk);
    check_eq("prog_we_t2", 32'(imem_we), 32'd1);
    check_eq("prog_we_addr", 32'(imem_addr), 32'd2);
    @(negedge clk);
    check_eq("prog_we_t3", 32'(imem_we), 32'd0);
    send_cmd(ZERO);
    check_eq("prog_zero_prog", 32'(imem_prog), 32'd1);
    send_cmd(IMEN);
    check_eq("prog_exit", 32'(imem_prog), 32'd0);
    check_eq("prog_hold_addr", 32'(imem_addr), 32'd2);
    check_eq("prog_hold_wdata", imem_wdata, 32'h0043_2806);
    check_eq("prog_we_cnt", 32'(we_cnt), 32'd1);
    check_eq("prog_last_addr", 32'(last_addr), 32'd2);
    check_eq("prog_last_wdata", last_wdata, 32'h0043_2806);

    // CCLK too early in the programming flow must not write
    base_we = we_cnt;
    send_cmd(IMEN);
    send_cmd(CCLK);
    send_cmd(32'h0000_0005);
    send_cmd(CCLK);
    repeat (3) @(negedge clk);
    check_eq("early_cclk_nowe", 32'(we_cnt - base_we), 32'd0);
    send_cmd(32'hDEAD_BEEF);
    send_cmd(CCLK);
    @(negedge clk);
    check_eq("late_cclk_we", 32'(we_cnt - base_we), 32'd1);
    check_eq("late_addr", 32'(last_addr), 32'd5);
    check_eq("late_wdata", last_wdata, 32'hDEAD_BEEF);
    send_cmd(IMEN);
    check_eq("late_exit", 32'(imem_prog), 32'd0);
    check_eq("prog_clk_low", 32'(clk_viol), 32'd0);

    // Inter-byte timeout after two bytes
    base_to = to_cnt;
    send_byte(8'hAA);
    send_byte(8'hBB);
    first_to = -1;
    for (int k = 1; k <= 3 * TC; k++) begin
      @(negedge clk);
      if (timeout && first_to < 0) first_to = k;
    end
    check_eq("to_delay", 32'(first_to), 32'(TC));
    check_eq("to_count", 32'(to_cnt - base_to), 32'd1);
    send_word(CCLK);
    check_eq("to_word", word, 32'h6B6C_6363);
    @(negedge clk);
    check_eq("to_cclk", 32'(cpu_clk), 32'd1);

    // A byte landing exactly on the expiry cycle is accepted
    send_cmd(ZERO);
    base_to = to_cnt;
    send_byte(8'h63);
    repeat (TC - 2) @(negedge clk);
    send_byte(8'h63);
    send_byte(8'h6C);
    send_byte(8'h6B);
    check_eq("edge_word", word, 32'h6B6C_6363);
    check_eq("edge_wvalid", 32'(word_valid), 32'd1);
    check_eq("edge_no_to", 32'(to_cnt - base_to), 32'd0);
    @(negedge clk);
    check_eq("edge_cclk", 32'(cpu_clk), 32'd1);

    // Reset mid-word
    send_cmd(RST0);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'h52;
    @(negedge clk);
    rx_data  = 8'h53;
    @(negedge clk);
    rx_data  = 8'h54;
    @(negedge clk);
    rx_valid = 1'b0;
    do_reset();
    check_reset_state("midword");
    send_cmd(RST0);
    check_eq("midword_fresh", 32'(cpu_reset), 32'd0);

    // Reset mid-programming
    send_cmd(IMEN);
    send_cmd(32'h0000_0007);
    send_cmd(32'h1122_3344);
    check_eq("midprog_addr_set", 32'(imem_addr), 32'd7);
    do_reset();
    check_reset_state("midprog");
    send_cmd(32'h0000_0009);
    check_eq("midprog_ignored", 32'(imem_addr), 32'd0);
    check_eq("midprog_noprog", 32'(imem_prog), 32'd0);
    send_cmd(RST0);
    check_eq("midprog_rst0", 32'(cpu_reset), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
